// File: rtl/regbus_pkg.sv
// Shared widths, FSM state encoding and requester ids for the register-bus arbiter.
package regbus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_I2C = 1'b0,
    REQ_SPI = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input winner picker with a last-grant pointer; FIXED_PRIO=1 makes I2C win every tie.
module rr_arb2
  import regbus_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_i2c_i,
  input  logic    req_spi_i,
  input  logic    upd_i,
  input  req_id_e upd_id_i,
  output logic    valid_o,
  output req_id_e winner_o
);

  req_id_e last_q;
  req_id_e last_d;

  // last-grant pointer register; reset value lets I2C take the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_SPI;
    end else begin
      last_q <= last_d;
    end
  end

  // pointer moves only when a grant is actually issued
  always_comb begin
    last_d = last_q;
    if (upd_i) begin
      last_d = upd_id_i;
    end else begin
      last_d = last_q;
    end
  end

  // winner selection
  always_comb begin
    valid_o  = req_i2c_i | req_spi_i;
    winner_o = REQ_I2C;
    if (req_i2c_i && req_spi_i) begin
      if (FIXED_PRIO != 0) begin
        winner_o = REQ_I2C;
      end else if (last_q == REQ_I2C) begin
        winner_o = REQ_SPI;
      end else begin
        winner_o = REQ_I2C;
      end
    end else if (req_spi_i) begin
      winner_o = REQ_SPI;
    end else begin
      winner_o = REQ_I2C;
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Arbitrates I2C and SPI register-bus requests onto one register-file port.
// Define REGBUS_ARB_GCNT_EN to build the per-requester 16-bit grant counters.
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_gnt,
  output logic              i2c_rvalid,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic              spi_gnt,
  output logic              spi_rvalid,
  output logic [DATA_W-1:0] spi_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [15:0]       i2c_gcnt,
  output logic [15:0]       spi_gcnt
);

  localparam int                LAT_W    = 2;
  localparam logic [LAT_W-1:0]  LAST_LAT = LAT_W'(RD_LATENCY - 1);

  state_e            state_q, state_d;
  req_id_e           win_q, win_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_d;
  logic [DATA_W-1:0] spi_rdata_q, spi_rdata_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic              i2c_gnt_q, i2c_gnt_d;
  logic              spi_gnt_q, spi_gnt_d;
  logic              i2c_rvalid_q, i2c_rvalid_d;
  logic              spi_rvalid_q, spi_rvalid_d;
  logic              arb_valid;
  req_id_e           arb_win;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i2c_i (i2c_req),
    .req_spi_i (spi_req),
    .upd_i     (state_q == ST_ISSUE),
    .upd_id_i  (win_q),
    .valid_o   (arb_valid),
    .winner_o  (arb_win)
  );

  // state, latched transaction and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      win_q        <= REQ_I2C;
      we_q         <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      lat_q        <= 2'd0;
      i2c_rdata_q  <= 8'h00;
      spi_rdata_q  <= 8'h00;
      reg_wr_q     <= 1'b0;
      reg_rd_q     <= 1'b0;
      i2c_gnt_q    <= 1'b0;
      spi_gnt_q    <= 1'b0;
      i2c_rvalid_q <= 1'b0;
      spi_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lat_q        <= lat_d;
      i2c_rdata_q  <= i2c_rdata_d;
      spi_rdata_q  <= spi_rdata_d;
      reg_wr_q     <= reg_wr_d;
      reg_rd_q     <= reg_rd_d;
      i2c_gnt_q    <= i2c_gnt_d;
      spi_gnt_q    <= spi_gnt_d;
      i2c_rvalid_q <= i2c_rvalid_d;
      spi_rvalid_q <= spi_rvalid_d;
    end
  end

  // next-state and next-output logic; pulses are computed one cycle ahead
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lat_d        = lat_q;
    i2c_rdata_d  = i2c_rdata_q;
    spi_rdata_d  = spi_rdata_q;
    reg_wr_d     = 1'b0;
    reg_rd_d     = 1'b0;
    i2c_gnt_d    = 1'b0;
    spi_gnt_d    = 1'b0;
    i2c_rvalid_d = 1'b0;
    spi_rvalid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_d = arb_win;
          if (arb_win == REQ_SPI) begin
            we_d    = spi_we;
            addr_d  = spi_addr;
            wdata_d = spi_wdata;
          end else begin
            we_d    = i2c_we;
            addr_d  = i2c_addr;
            wdata_d = i2c_wdata;
          end
          reg_wr_d  = we_d;
          reg_rd_d  = ~we_d;
          i2c_gnt_d = (arb_win == REQ_I2C);
          spi_gnt_d = (arb_win == REQ_SPI);
          state_d   = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        lat_d = 2'd0;
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // capture on the final latency cycle so rvalid lines up with the data
        if (lat_q == LAST_LAT) begin
          if (win_q == REQ_SPI) begin
            spi_rdata_d  = reg_rdata;
            spi_rvalid_d = 1'b1;
          end else begin
            i2c_rdata_d  = reg_rdata;
            i2c_rvalid_d = 1'b1;
          end
          state_d = ST_RESP;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef REGBUS_ARB_GCNT_EN
  logic [15:0] i2c_gcnt_q;
  logic [15:0] spi_gcnt_q;

  // grant counters advance after each grant pulse and wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2c_gcnt_q <= 16'h0000;
      spi_gcnt_q <= 16'h0000;
    end else begin
      if (i2c_gnt_q) begin
        i2c_gcnt_q <= i2c_gcnt_q + 16'h0001;
      end
      if (spi_gnt_q) begin
        spi_gcnt_q <= spi_gcnt_q + 16'h0001;
      end
    end
  end

  assign i2c_gcnt = i2c_gcnt_q;
  assign spi_gcnt = spi_gcnt_q;
`else
  assign i2c_gcnt = 16'h0000;
  assign spi_gcnt = 16'h0000;
`endif

  assign i2c_gnt    = i2c_gnt_q;
  assign spi_gnt    = spi_gnt_q;
  assign i2c_rvalid = i2c_rvalid_q;
  assign spi_rvalid = spi_rvalid_q;
  assign i2c_rdata  = i2c_rdata_q;
  assign spi_rdata  = spi_rdata_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign reg_wr     = reg_wr_q;
  assign reg_rd     = reg_rd_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench: round-robin instance (RD_LATENCY=1) and fixed-priority instance (RD_LATENCY=3).
module tb_regbus_arbiter;

  typedef struct {
    logic       is_spi;
    logic [7:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  resp_t exp_q[$];

  logic       a_i2c_req, a_i2c_we, a_i2c_gnt, a_i2c_rvalid;
  logic [7:0] a_i2c_addr, a_i2c_wdata, a_i2c_rdata;
  logic       a_spi_req, a_spi_we, a_spi_gnt, a_spi_rvalid;
  logic [7:0] a_spi_addr, a_spi_wdata, a_spi_rdata;
  logic [7:0] a_reg_addr, a_reg_wdata, a_reg_rdata;
  logic       a_reg_wr, a_reg_rd;
  logic [15:0] a_i2c_gcnt, a_spi_gcnt;

  logic       b_i2c_req, b_i2c_we, b_i2c_gnt, b_i2c_rvalid;
  logic [7:0] b_i2c_addr, b_i2c_wdata, b_i2c_rdata;
  logic       b_spi_req, b_spi_we, b_spi_gnt, b_spi_rvalid;
  logic [7:0] b_spi_addr, b_spi_wdata, b_spi_rdata;
  logic [7:0] b_reg_addr, b_reg_wdata, b_reg_rdata;
  logic       b_reg_wr, b_reg_rd;
  logic [15:0] b_i2c_gcnt, b_spi_gcnt;

  logic       a_pipe;
  logic [2:0] b_pipe;

  always #5 clk = ~clk;

  regbus_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i2c_req(a_i2c_req), .i2c_we(a_i2c_we), .i2c_addr(a_i2c_addr), .i2c_wdata(a_i2c_wdata),
    .i2c_gnt(a_i2c_gnt), .i2c_rvalid(a_i2c_rvalid), .i2c_rdata(a_i2c_rdata),
    .spi_req(a_spi_req), .spi_we(a_spi_we), .spi_addr(a_spi_addr), .spi_wdata(a_spi_wdata),
    .spi_gnt(a_spi_gnt), .spi_rvalid(a_spi_rvalid), .spi_rdata(a_spi_rdata),
    .reg_addr(a_reg_addr), .reg_wdata(a_reg_wdata), .reg_wr(a_reg_wr), .reg_rd(a_reg_rd),
    .reg_rdata(a_reg_rdata), .i2c_gcnt(a_i2c_gcnt), .spi_gcnt(a_spi_gcnt)
  );

  regbus_arbiter #(.RD_LATENCY(3), .FIXED_PRIO(1)) u_dut_fix (
    .clk(clk), .rst_n(rst_n),
    .i2c_req(b_i2c_req), .i2c_we(b_i2c_we), .i2c_addr(b_i2c_addr), .i2c_wdata(b_i2c_wdata),
    .i2c_gnt(b_i2c_gnt), .i2c_rvalid(b_i2c_rvalid), .i2c_rdata(b_i2c_rdata),
    .spi_req(b_spi_req), .spi_we(b_spi_we), .spi_addr(b_spi_addr), .spi_wdata(b_spi_wdata),
    .spi_gnt(b_spi_gnt), .spi_rvalid(b_spi_rvalid), .spi_rdata(b_spi_rdata),
    .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata), .reg_wr(b_reg_wr), .reg_rd(b_reg_rd),
    .reg_rdata(b_reg_rdata), .i2c_gcnt(b_i2c_gcnt), .spi_gcnt(b_spi_gcnt)
  );

  // register-file model: data valid only in the cycle exactly RD_LATENCY after the strobe
  function automatic logic [7:0] rf(input logic [7:0] a);
    return a ^ 8'h3E;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pipe <= 1'b0;
      b_pipe <= 3'b000;
    end else begin
      a_pipe <= a_reg_rd;
      b_pipe <= {b_pipe[1:0], b_reg_rd};
    end
  end

  assign a_reg_rdata = a_pipe    ? rf(a_reg_addr) : 8'hEE;
  assign b_reg_rdata = b_pipe[2] ? rf(b_reg_addr) : 8'hEE;

  function automatic logic [31:0] gexp(input int n);
`ifdef REGBUS_ARB_GCNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic iv, input logic sv, input logic [7:0] d);
    resp_t e;
    chk({tag, "_sbq"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_who"}, {iv, sv}, e.is_spi ? 32'd1 : 32'd2);
      chk({tag, "_data"}, d, {24'd0, e.data});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] a_ctl();
    return {a_i2c_gnt, a_spi_gnt, a_reg_wr, a_reg_rd};
  endfunction

  function automatic logic [3:0] b_ctl();
    return {b_i2c_gnt, b_spi_gnt, b_reg_wr, b_reg_rd};
  endfunction

  initial begin
    {a_i2c_req, a_i2c_we, a_i2c_addr, a_i2c_wdata} = 18'd0;
    {a_spi_req, a_spi_we, a_spi_addr, a_spi_wdata} = 18'd0;
    {b_i2c_req, b_i2c_we, b_i2c_addr, b_i2c_wdata} = 18'd0;
    {b_spi_req, b_spi_we, b_spi_addr, b_spi_wdata} = 18'd0;

    // reset state
    #12;
    chk("rst_ctl", {a_ctl(), a_i2c_rvalid, a_spi_rvalid}, 32'd0);
    chk("rst_dat", {a_reg_addr, a_reg_wdata, a_i2c_rdata, a_spi_rdata}, 32'd0);
    chk("rst_cnt", {a_i2c_gcnt, a_spi_gcnt}, 32'd0);
    chk("rst_fix", {b_ctl(), b_i2c_rvalid, b_spi_rvalid, b_reg_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // I2C write 0x01 <- 0xA5
    a_i2c_req = 1'b1; a_i2c_we = 1'b1; a_i2c_addr = 8'h01; a_i2c_wdata = 8'hA5;
    step();
    chk("wr_ctl", a_ctl(), 32'b1010);
    chk("wr_bus", {a_reg_addr, a_reg_wdata}, 32'h01A5);
    a_i2c_req = 1'b0;
    step();
    chk("wr_after", {a_ctl(), a_i2c_rvalid, a_spi_rvalid}, 32'd0);
    chk("wr_hold", {a_reg_addr, a_reg_wdata}, 32'h01A5);

    // SPI read 0x02 -> 0x3C, rvalid three cycles after request
    a_spi_req = 1'b1; a_spi_we = 1'b0; a_spi_addr = 8'h02; a_spi_wdata = 8'hFF;
    exp_q.push_back('{1'b1, 8'h3C});
    step();
    chk("rd_ctl", a_ctl(), 32'b0101);
    chk("rd_addr", a_reg_addr, 32'h02);
    a_spi_req = 1'b0;
    step();
    chk("rd_early", {a_i2c_rvalid, a_spi_rvalid}, 32'd0);
    step();
    pop_check("rd_resp", a_i2c_rvalid, a_spi_rvalid, a_spi_rdata);
    chk("rd_i2c_untouched", a_i2c_rdata, 32'd0);
    step();
    chk("rd_rv_pulse", {a_i2c_rvalid, a_spi_rvalid}, 32'd0);
    chk("rd_rdata_hold", a_spi_rdata, 32'h3C);

    // both requesters writing continuously: strict alternation
    a_i2c_req = 1'b1; a_i2c_we = 1'b1; a_i2c_addr = 8'h10; a_i2c_wdata = 8'h11;
    a_spi_req = 1'b1; a_spi_we = 1'b1; a_spi_addr = 8'h20; a_spi_wdata = 8'h22;
    for (int k = 1; k <= 8; k++) begin
      step();
      if ((k % 2) == 1) begin
        chk($sformatf("rr_ctl%0d", k), a_ctl(), (((k - 1) / 2) % 2 == 0) ? 32'b1010 : 32'b0110);
        chk($sformatf("rr_bus%0d", k), {a_reg_addr, a_reg_wdata},
            (((k - 1) / 2) % 2 == 0) ? 32'h1011 : 32'h2022);
      end else begin
        chk($sformatf("rr_ctl%0d", k), a_ctl(), 32'd0);
      end
    end
    a_i2c_req = 1'b0; a_spi_req = 1'b0;
    step();
    chk("rr_stop", a_ctl(), 32'd0);
    chk("cnt_i2c", a_i2c_gcnt, gexp(3));
    chk("cnt_spi", a_spi_gcnt, gexp(3));

    // SPI request arriving during an I2C read waits its turn
    a_i2c_req = 1'b1; a_i2c_we = 1'b0; a_i2c_addr = 8'h40;
    exp_q.push_back('{1'b0, 8'h7E});
    step();
    chk("bz_ctl1", a_ctl(), 32'b1001);
    a_i2c_req = 1'b0;
    a_spi_req = 1'b1; a_spi_we = 1'b1; a_spi_addr = 8'h55; a_spi_wdata = 8'h99;
    step();
    chk("bz_ctl2", {a_ctl(), a_i2c_rvalid, a_spi_rvalid}, 32'd0);
    step();
    pop_check("bz_resp", a_i2c_rvalid, a_spi_rvalid, a_i2c_rdata);
    chk("bz_ctl3", a_ctl(), 32'd0);
    step();
    chk("bz_ctl4", a_ctl(), 32'd0);
    step();
    chk("bz_spi_ctl", a_ctl(), 32'b0110);
    chk("bz_spi_bus", {a_reg_addr, a_reg_wdata}, 32'h5599);
    chk("bz_rdata_hold", {a_i2c_rdata, a_spi_rdata}, 32'h7E3C);
    a_spi_req = 1'b0;
    step();
    chk("bz_done", a_ctl(), 32'd0);

    // reset while an I2C read is in WAIT
    a_i2c_req = 1'b1; a_i2c_we = 1'b0; a_i2c_addr = 8'h33;
    step();
    chk("ab_ctl", a_ctl(), 32'b1001);
    a_i2c_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("ab_rst_ctl", {a_ctl(), a_i2c_rvalid, a_spi_rvalid}, 32'd0);
    chk("ab_rst_dat", {a_reg_addr, a_reg_wdata, a_i2c_rdata, a_spi_rdata}, 32'd0);
    chk("ab_rst_cnt", {a_i2c_gcnt, a_spi_gcnt}, 32'd0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("ab_quiet%0d", k), {a_ctl(), a_i2c_rvalid, a_spi_rvalid}, 32'd0);
    end
    // pointer back to SPI-last: I2C wins the tie even though I2C was granted last
    a_i2c_req = 1'b1; a_i2c_we = 1'b1; a_i2c_addr = 8'h10; a_i2c_wdata = 8'h11;
    a_spi_req = 1'b1; a_spi_we = 1'b1; a_spi_addr = 8'h20; a_spi_wdata = 8'h22;
    step();
    chk("ab_ptr", a_ctl(), 32'b1010);
    a_i2c_req = 1'b0; a_spi_req = 1'b0;
    step();

    // fixed priority: I2C wins every tie, SPI served once I2C drops
    b_i2c_req = 1'b1; b_i2c_we = 1'b1; b_i2c_addr = 8'hA0; b_i2c_wdata = 8'h01;
    b_spi_req = 1'b1; b_spi_we = 1'b1; b_spi_addr = 8'hB0; b_spi_wdata = 8'h02;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("fx_ctl%0d", k), b_ctl(), ((k % 2) == 1) ? 32'b1010 : 32'd0);
    end
    b_i2c_req = 1'b0;
    step();
    chk("fx_spi", b_ctl(), 32'b0110);
    chk("fx_spi_bus", {b_reg_addr, b_reg_wdata}, 32'hB002);
    b_spi_req = 1'b0;
    step();
    chk("fx_idle", b_ctl(), 32'd0);

    // RD_LATENCY=3 read: rvalid five cycles after request
    b_i2c_req = 1'b1; b_i2c_we = 1'b0; b_i2c_addr = 8'h0F;
    exp_q.push_back('{1'b0, 8'h31});
    step();
    chk("l3_ctl", b_ctl(), 32'b1001);
    b_i2c_req = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("l3_wait%0d", k), {b_i2c_rvalid, b_spi_rvalid}, 32'd0);
    end
    step();
    pop_check("l3_resp", b_i2c_rvalid, b_spi_rvalid, b_i2c_rdata);
    step();
    chk("l3_pulse", {b_i2c_rvalid, b_spi_rvalid}, 32'd0);
    chk("l3_hold", b_i2c_rdata, 32'h31);
    chk("fx_cnt_i2c", b_i2c_gcnt, gexp(4));
    chk("fx_cnt_spi", b_spi_gcnt, gexp(1));
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
